// File: rtl/add_arbiter_if.sv
// add_arbiter_if: requester/consumer bus of add_arbiter; slave = arbiter, master = requesters and consumer (z_carry only with ADD_ARBITER_CARRY_EN)
interface add_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [31:0] a0, a1, a2, a3;
  logic [31:0] b0, b1, b2, b3;
  logic [31:0] z;
  logic z_valid;
  logic [1:0] z_id;
  logic z_ready;
  logic [15:0] op_count;
`ifdef ADD_ARBITER_CARRY_EN
  logic z_carry;
`endif
  modport master(
`ifdef ADD_ARBITER_CARRY_EN
    input z_carry,
`endif
    output req, a0, a1, a2, a3, b0, b1, b2, b3, z_ready,
    input gnt, z, z_valid, z_id, op_count
  );
  modport slave(
`ifdef ADD_ARBITER_CARRY_EN
    output z_carry,
`endif
    input req, a0, a1, a2, a3, b0, b1, b2, b3, z_ready,
    output gnt, z, z_valid, z_id, op_count
  );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one 32-bit adder among 4 requesters; ports clk, reset_n (async, active-low), bus (add_arbiter_if.slave); optional z_carry with ADD_ARBITER_CARRY_EN
module add_arbiter (
  input logic clk,
  input logic reset_n,
  add_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
`ifdef ADD_ARBITER_CARRY_EN
  localparam int W = 33;
  logic carry_q, carry_d;
`else
  localparam int W = 32;
`endif
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win, z_id_q, z_id_d;
  logic [31:0] z_q, z_d, sel_a, sel_b;
  logic [W-1:0] sum;
  logic [15:0] cnt_q, cnt_d;
  logic grant, accept;
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--) win = bus.req[ptr_q + 2'(i)] ? ptr_q + 2'(i) : win;
    accept = state_q == FULL && bus.z_ready;
    grant = reset_n && |bus.req && (state_q == EMPTY || bus.z_ready);
    sel_a = win == 2'd0 ? bus.a0 : win == 2'd1 ? bus.a1 : win == 2'd2 ? bus.a2 : bus.a3;
    sel_b = win == 2'd0 ? bus.b0 : win == 2'd1 ? bus.b1 : win == 2'd2 ? bus.b2 : bus.b3;
    sum = W'(sel_a) + W'(sel_b);
    state_d = grant ? FULL : accept ? EMPTY : state_q;
    ptr_d = grant ? win + 2'd1 : ptr_q;
    z_d = grant ? sum[31:0] : z_q;
    z_id_d = grant ? win : z_id_q;
`ifdef ADD_ARBITER_CARRY_EN
    carry_d = grant ? sum[32] : carry_q;
`endif
    cnt_d = cnt_q + 16'(accept);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      z_q <= '0;
      z_id_q <= '0;
      cnt_q <= '0;
`ifdef ADD_ARBITER_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      z_q <= z_d;
      z_id_q <= z_id_d;
      cnt_q <= cnt_d;
`ifdef ADD_ARBITER_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end
  assign bus.gnt = grant ? 4'b0001 << win : 4'b0000;
  assign bus.z = z_q;
  assign bus.z_valid = state_q == FULL;
  assign bus.z_id = z_id_q;
  assign bus.op_count = cnt_q;
`ifdef ADD_ARBITER_CARRY_EN
  assign bus.z_carry = carry_q;
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: scoreboard bench for add_arbiter with an independent arbitration model
module tb_add_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic c;
    logic [31:0] s;
  } res_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic zr = 1'b0;
  logic [31:0] a [4];
  logic [31:0] b [4];
  int checks = 0;
  int errors = 0;
  int ngr = 0;
  int cnt0;
  int target;
  logic m_full = 1'b0;
  int m_ptr = 0;
  logic [15:0] m_cnt = '0;
  res_t q[$];
  add_arbiter_if ifc ();
  assign ifc.req = req;
  assign ifc.z_ready = zr;
  assign ifc.a0 = a[0];
  assign ifc.a1 = a[1];
  assign ifc.a2 = a[2];
  assign ifc.a3 = a[3];
  assign ifc.b0 = b[0];
  assign ifc.b1 = b[1];
  assign ifc.b2 = b[2];
  assign ifc.b3 = b[3];
  add_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  // reference arbiter: rotating search with early exit
  always @(negedge clk) begin
    if (!reset_n) begin
      m_full = 1'b0;
      m_ptr = 0;
      m_cnt = '0;
      q.delete();
    end else begin
      logic [3:0] eg;
      int k;
      logic [32:0] s;
      eg = '0;
      k = 0;
      if (req != 4'd0 && (!m_full || zr)) begin
        for (int i = 0; i < 4; i++) begin
          k = (m_ptr + i) % 4;
          if (req[k]) break;
        end
        eg[k] = 1'b1;
      end
      chk("gnt", 32'(ifc.gnt), 32'(eg));
      chk("z_valid", 32'(ifc.z_valid), 32'(m_full));
      chk("op_count", 32'(ifc.op_count), 32'(m_cnt));
      if (m_full && zr) m_cnt = m_cnt + 16'd1;
      if (eg != 4'd0) begin
        s = {1'b0, a[k]} + {1'b0, b[k]};
        q.push_back('{id: 2'(k), c: s[32], s: s[31:0]});
        m_ptr = (k + 1) % 4;
        m_full = 1'b1;
        ngr++;
      end else if (m_full && zr) m_full = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (reset_n && ifc.z_valid && zr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop actual=result expected=none");
      end else begin
        res_t e;
        e = q.pop_front();
        chk("z", ifc.z, e.s);
        chk("z_id", 32'(ifc.z_id), 32'(e.id));
`ifdef ADD_ARBITER_CARRY_EN
        chk("z_carry", 32'(ifc.z_carry), 32'(e.c));
`endif
      end
    end
  end
  initial begin
    for (int k = 0; k < 4; k++) begin
      a[k] = '0;
      b[k] = '0;
    end
    req = 4'b1111;
    #3;
    chk("rst_gnt", 32'(ifc.gnt), 32'd0);
    chk("rst_z", ifc.z, 32'd0);
    chk("rst_z_valid", 32'(ifc.z_valid), 32'd0);
    chk("rst_z_id", 32'(ifc.z_id), 32'd0);
    chk("rst_op_count", 32'(ifc.op_count), 32'd0);
    req = '0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    req = 4'b0001; a[0] = 32'h5; b[0] = 32'h3; zr = 1'b1;
    #2 chk("first_gnt", 32'(ifc.gnt), 32'h1);
    cyc();
    req = '0;
    #2 chk("first_z", ifc.z, 32'h8);
    chk("first_z_id", 32'(ifc.z_id), 32'd0);
    chk("first_z_valid", 32'(ifc.z_valid), 32'd1);
    cyc();
    #2 chk("first_op_count", 32'(ifc.op_count), 32'd1);
    cyc();
    req = 4'b1000; a[3] = 32'h1; b[3] = 32'h1;
    #2 chk("ptr_to0_gnt", 32'(ifc.gnt), 32'h8);
    cyc();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      a[k] = 32'(k * 16);
      b[k] = 32'(k);
    end
    for (int i = 0; i < 5; i++) begin
      #2 chk("rr_gnt", 32'(ifc.gnt), 32'(1 << (i % 4)));
      chk("rr_z_valid", 32'(ifc.z_valid), 32'd1);
      chk("rr_z_id", 32'(ifc.z_id), 32'((i + 3) % 4));
      cyc();
    end
    req = '0;
    #2 chk("rr_last_z_id", 32'(ifc.z_id), 32'd0);
    cyc();
    req = 4'b0100; a[2] = 32'hFFFF_FFFF; b[2] = 32'h2;
    #2 chk("ovf_gnt", 32'(ifc.gnt), 32'h4);
    cyc();
    req = '0;
    #2 chk("ovf_z", ifc.z, 32'h1);
    chk("ovf_z_id", 32'(ifc.z_id), 32'd2);
`ifdef ADD_ARBITER_CARRY_EN
    chk("ovf_carry", 32'(ifc.z_carry), 32'd1);
`endif
    cyc();
    req = 4'b0010; a[1] = 32'h8; b[1] = 32'h8;
    #2 chk("stall_pre_gnt", 32'(ifc.gnt), 32'h2);
    cyc();
    zr = 1'b0; a[1] = 32'h5; b[1] = 32'h5;
    cnt0 = int'(m_cnt);
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_gnt", 32'(ifc.gnt), 32'd0);
      chk("stall_z", ifc.z, 32'h10);
      chk("stall_z_id", 32'(ifc.z_id), 32'd1);
      chk("stall_op_count", 32'(ifc.op_count), 32'(cnt0));
      cyc();
    end
    zr = 1'b1;
    #2 chk("unstall_gnt", 32'(ifc.gnt), 32'h2);
    cyc();
    #2 chk("unstall_op_count", 32'(ifc.op_count), 32'(cnt0 + 1));
    chk("unstall_z", ifc.z, 32'ha);
    cyc();
    zr = 1'b0; req = 4'b1000; a[3] = 32'h7; b[3] = 32'h9;
    #2 chk("pre_rst_full", 32'(ifc.z_valid), 32'd1);
    reset_n = 1'b0;
    #1 chk("async_z_valid", 32'(ifc.z_valid), 32'd0);
    chk("async_gnt", 32'(ifc.gnt), 32'd0);
    chk("async_op_count", 32'(ifc.op_count), 32'd0);
    chk("async_z", ifc.z, 32'd0);
    repeat (2) cyc();
    reset_n = 1'b1; zr = 1'b1;
    #2 chk("post_rst_gnt", 32'(ifc.gnt), 32'h8);
    cyc();
    req = '0;
    #2 chk("post_rst_z", ifc.z, 32'h10);
    chk("post_rst_z_id", 32'(ifc.z_id), 32'd3);
    target = ngr + 512;
    for (int c = 0; c < 8000 && ngr < target; c++) begin
      cyc();
      req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        a[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b[k] = $urandom;
      end
      zr = $urandom_range(0, 3) != 0;
    end
    cyc();
    chk("rand_grants", 32'(ngr >= target), 32'd1);
    req = '0; zr = 1'b1;
    repeat (3) cyc();
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_z_valid", 32'(ifc.z_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req  input  4  per-requester request; bit k = requester k.
REQ-004 SHALL have port: a0..a3  input  32 each  augend of requester k.
REQ-005 SHALL have port: b0..b3  input  32 each  addend of requester k.
REQ-006 SHALL have port: gnt  output  4  one-hot grant; operands of granted requester are captured at that clock edge.
REQ-007 SHALL have port: z  output  32  registered sum.
REQ-008 SHALL have port: z_valid  output  1  z holds a valid result.
REQ-009 SHALL have port: z_id  output  2  index of the requester that owns z.
REQ-010 SHALL have port: z_ready  input  1  consumer accepts z when z_valid && z_ready.
REQ-011 SHALL have port: op_count  output  16  number of results accepted by the consumer.

Function
REQ-012 SHALL share one 32-bit adder among four requesters; sum = (a+b) mod 2^32, carry dropped from z.
REQ-013 SHALL have output register states EMPTY (z_valid=0) and FULL (z_valid=1).
REQ-014 SHALL issue a grant only when req!=0 and (EMPTY, or FULL with z_ready=1); otherwise gnt=0.
REQ-015 gnt SHALL be combinational from req, pointer ptr[1:0], z_valid, z_ready; at most one bit set.
REQ-016 SHALL arbitrate round-robin: search ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
REQ-017 On a grant to k, ptr SHALL become (k+1) mod 4 at the next edge; without a grant, ptr SHALL hold.
REQ-018 On a grant to k, at the next edge z SHALL = ak+bk, z_id SHALL = k, z_valid SHALL = 1 (latency one cycle).
REQ-019 FULL with z_ready=1 and no grant SHALL go to EMPTY; FULL with z_ready=0 SHALL hold z, z_id, z_valid unchanged.
REQ-020 Accept and new grant in the same cycle SHALL be allowed; throughput one result per cycle.
REQ-021 op_count SHALL increment by 1 on every cycle with z_valid && z_ready, wrapping 0xFFFF -> 0x0000.
REQ-022 Requester SHALL hold req and operands until it sees its gnt bit; it may keep req high for further operations.
REQ-023 A requester that drops req before its grant SHALL lose its pending request with no side effect.
REQ-024 z SHALL not change while EMPTY (holds last value).

Reset
REQ-025 While reset_n=0: gnt=0, z=0, z_valid=0, z_id=0, op_count=0, ptr=0, state EMPTY, immediately (asynchronous).
REQ-026 Reset mid-operation SHALL discard any held result without incrementing op_count; first grant after release follows ptr=0.

Configuration
REQ-027 With macro ADD_ARBITER_CARRY_EN defined, the block SHALL add output z_carry (1 bit), registered with z, = carry-out of ak+bk, reset 0, held under stall.
REQ-028 Without ADD_ARBITER_CARRY_EN, z_carry SHALL not exist and behaviour SHALL otherwise be identical.

Verification
REQ-029 Reset, then req=4'b0001, a0=0x00000005, b0=0x00000003, z_ready=1 -> gnt=0001 same cycle; next cycle z=0x00000008, z_id=0, z_valid=1; op_count=1 after accept.
REQ-030 req=4'b1111 held, z_ready=1, from ptr=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; z_id sequence 0,1,2,3,0; z_valid continuously 1.
REQ-031 Overflow: a2=0xFFFFFFFF, b2=0x00000002 -> z=0x00000001; with ADD_ARBITER_CARRY_EN, z_carry=1.
REQ-032 Stall: result z=0x00000010 FULL, z_ready=0 for 3 cycles with req=4'b0010 -> gnt=0, z/z_id stable, op_count unchanged; z_ready=1 -> grant to 1 in that cycle, op_count+1.
REQ-033 Assert reset_n=0 while FULL with req pending -> z_valid=0, gnt=0, op_count=0 immediately; after release req=4'b1000 -> gnt=1000.
REQ-034 Random bench: 512 operations, all requesters random req/operands, random z_ready -> every accepted z equals the scoreboarded ak+bk for z_id, no grant lost or duplicated, zero mismatches reported.
